// File: rtl/otter_mem_arbiter.sv
// rtl/otter_mem_arbiter.sv - round-robin arbiter sharing OTTER data memory port 2 between CPU and DMA
//
// Purpose: sequences each access through ST_IDLE -> ST_ACCESS (-> ST_RESP for reads),
// grants requesters round-robin and rejects misaligned accesses before memory sees them.
//
// Ports:
//   CLK, RESET_N                  clock (rising edge), asynchronous active-low reset
//   REQx/WEx/ADDRx/WDATAx/SIZEx/SIGNx   requester x (0 = CPU, 1 = DMA/debug) access fields
//   GNTx, ERRx, RVALIDx, RDATAx  per-requester grant, reject, read-valid pulses and read data
//   MEM_RDEN2, MEM_WE2            memory strobes, asserted only in ST_ACCESS
//   MEM_ADDR2, MEM_DIN2, MEM_SIZE, MEM_SIGN   latched access fields to memory
//   MEM_DOUT2                     memory read data, valid the cycle after MEM_RDEN2
module otter_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              REQ0,
  input  logic              REQ1,
  input  logic              WE0,
  input  logic              WE1,
  input  logic [ADDR_W-1:0] ADDR0,
  input  logic [ADDR_W-1:0] ADDR1,
  input  logic [DATA_W-1:0] WDATA0,
  input  logic [DATA_W-1:0] WDATA1,
  input  logic [1:0]        SIZE0,
  input  logic [1:0]        SIZE1,
  input  logic              SIGN0,
  input  logic              SIGN1,
  output logic              GNT0,
  output logic              GNT1,
  output logic              ERR0,
  output logic              ERR1,
  output logic              RVALID0,
  output logic              RVALID1,
  output logic [DATA_W-1:0] RDATA0,
  output logic [DATA_W-1:0] RDATA1,
  output logic              MEM_RDEN2,
  output logic              MEM_WE2,
  output logic [ADDR_W-1:0] MEM_ADDR2,
  output logic [DATA_W-1:0] MEM_DIN2,
  output logic [1:0]        MEM_SIZE,
  output logic              MEM_SIGN,
  input  logic [DATA_W-1:0] MEM_DOUT2
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;
  logic                last_q, last_d;
  logic                we_q, we_d;
  logic                illegal_q, illegal_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   din_q, din_d;
  logic [1:0]          size_q, size_d;
  logic                sign_q, sign_d;

  // Selection and the selected requester's fields
  logic                sel;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic [1:0]          sel_size;
  logic                sel_sign;
  logic                sel_illegal;

  // On a tie the requester that was not granted last wins; otherwise the lone requester wins.
  always_comb begin
    if (REQ0 && REQ1) begin
      sel = ~last_q;
    end else begin
      sel = REQ1;
    end
  end

  assign sel_we    = sel ? WE1    : WE0;
  assign sel_addr  = sel ? ADDR1  : ADDR0;
  assign sel_wdata = sel ? WDATA1 : WDATA0;
  assign sel_size  = sel ? SIZE1  : SIZE0;
  assign sel_sign  = sel ? SIGN1  : SIGN0;

  always_comb begin
    case (sel_size)
      2'd0:    sel_illegal = 1'b0;
      2'd1:    sel_illegal = sel_addr[0];
      2'd2:    sel_illegal = (sel_addr[1:0] != 2'b00);
      default: sel_illegal = 1'b1;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= ST_IDLE;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      we_q      <= 1'b0;
      illegal_q <= 1'b0;
      addr_q    <= '0;
      din_q     <= '0;
      size_q    <= 2'd0;
      sign_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      we_q      <= we_d;
      illegal_q <= illegal_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      size_q    <= size_d;
      sign_q    <= sign_d;
    end
  end

  // Next-state logic; access fields are captured only when a request is taken in ST_IDLE
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    we_d      = we_q;
    illegal_d = illegal_q;
    addr_d    = addr_q;
    din_d     = din_q;
    size_d    = size_q;
    sign_d    = sign_q;
    case (state_q)
      ST_IDLE: begin
        if (REQ0 || REQ1) begin
          state_d   = ST_ACCESS;
          owner_d   = sel;
          last_d    = sel;
          we_d      = sel_we;
          illegal_d = sel_illegal;
          addr_d    = sel_addr;
          din_d     = sel_wdata;
          size_d    = sel_size;
          sign_d    = sel_sign;
        end
      end
      ST_ACCESS: begin
        // Rejected accesses and writes have no response phase
        if (illegal_q || we_q) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode; unknown encodings fall to the all-zero default
  always_comb begin
    GNT0      = 1'b0;
    GNT1      = 1'b0;
    ERR0      = 1'b0;
    ERR1      = 1'b0;
    RVALID0   = 1'b0;
    RVALID1   = 1'b0;
    RDATA0    = '0;
    RDATA1    = '0;
    MEM_RDEN2 = 1'b0;
    MEM_WE2   = 1'b0;
    case (state_q)
      ST_ACCESS: begin
        GNT0 = ~owner_q;
        GNT1 = owner_q;
        if (illegal_q) begin
          ERR0 = ~owner_q;
          ERR1 = owner_q;
        end else if (we_q) begin
          MEM_WE2 = 1'b1;
        end else begin
          MEM_RDEN2 = 1'b1;
        end
      end
      ST_RESP: begin
        if (owner_q) begin
          RVALID1 = 1'b1;
          RDATA1  = MEM_DOUT2;
        end else begin
          RVALID0 = 1'b1;
          RDATA0  = MEM_DOUT2;
        end
      end
      default: begin
      end
    endcase
  end

  assign MEM_ADDR2 = addr_q;
  assign MEM_DIN2  = din_q;
  assign MEM_SIZE  = size_q;
  assign MEM_SIGN  = sign_q;

endmodule

// File: tb/tb_otter_mem_arbiter.sv
// tb/tb_otter_mem_arbiter.sv - directed self-checking bench for otter_mem_arbiter
module tb_otter_mem_arbiter;

  logic        CLK, RESET_N;
  logic        REQ0, REQ1, WE0, WE1, SIGN0, SIGN1;
  logic [31:0] ADDR0, ADDR1, WDATA0, WDATA1, MEM_DOUT2;
  logic [1:0]  SIZE0, SIZE1;
  logic        GNT0, GNT1, ERR0, ERR1, RVALID0, RVALID1, MEM_RDEN2, MEM_WE2, MEM_SIGN;
  logic [31:0] RDATA0, RDATA1, MEM_ADDR2, MEM_DIN2;
  logic [1:0]  MEM_SIZE;

  otter_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .REQ0(REQ0), .REQ1(REQ1), .WE0(WE0), .WE1(WE1),
    .ADDR0(ADDR0), .ADDR1(ADDR1), .WDATA0(WDATA0), .WDATA1(WDATA1),
    .SIZE0(SIZE0), .SIZE1(SIZE1), .SIGN0(SIGN0), .SIGN1(SIGN1),
    .GNT0(GNT0), .GNT1(GNT1), .ERR0(ERR0), .ERR1(ERR1),
    .RVALID0(RVALID0), .RVALID1(RVALID1), .RDATA0(RDATA0), .RDATA1(RDATA1),
    .MEM_RDEN2(MEM_RDEN2), .MEM_WE2(MEM_WE2), .MEM_ADDR2(MEM_ADDR2), .MEM_DIN2(MEM_DIN2),
    .MEM_SIZE(MEM_SIZE), .MEM_SIGN(MEM_SIGN), .MEM_DOUT2(MEM_DOUT2)
  );

  // Strobe vector bit positions: {GNT0,GNT1,ERR0,ERR1,RVALID0,RVALID1,MEM_RDEN2,MEM_WE2}
  localparam logic [7:0] G0 = 8'h80, G1 = 8'h40, E0 = 8'h20, RV0 = 8'h08, RV1 = 8'h04,
                         RD = 8'h02, WR = 8'h01;

  typedef struct {
    logic        owner;
    logic [31:0] data;
  } rsp_t;

  rsp_t rsp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] outs();
    return {GNT0, GNT1, ERR0, ERR1, RVALID0, RVALID1, MEM_RDEN2, MEM_WE2};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic pop_rsp(input string tag);
    rsp_t e;
    if (rsp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s: observed response with empty scoreboard", tag);
    end else begin
      e = rsp_q.pop_front();
      chk({tag, "_owner"}, {31'd0, RVALID1}, {31'd0, e.owner});
      chk({tag, "_data"}, RVALID1 ? RDATA1 : RDATA0, e.data);
      chk({tag, "_other_rdata"}, RVALID1 ? RDATA0 : RDATA1, 32'd0);
    end
  endtask

  initial begin
    int          ng;
    int          nrv;
    int          g0_cyc;
    logic [31:0] bad_addr [3];
    logic [1:0]  bad_size [3];

    REQ0 = 0; REQ1 = 0; WE0 = 0; WE1 = 0; SIGN0 = 0; SIGN1 = 0;
    ADDR0 = 0; ADDR1 = 0; WDATA0 = 0; WDATA1 = 0; SIZE0 = 0; SIZE1 = 0; MEM_DOUT2 = 0;
    RESET_N = 0;

    // Reset state
    #3;
    chk("reset_strobes", {24'd0, outs()}, 32'd0);
    chk("reset_addr", MEM_ADDR2, 32'd0);
    chk("reset_din_size_sign", {MEM_DIN2[28:0], MEM_SIZE, MEM_SIGN}, 32'd0);
    tick();
    tick();
    RESET_N = 1;
    tick();
    chk("idle_after_reset", {24'd0, outs()}, 32'd0);

    // CPU word read
    REQ0 = 1; WE0 = 0; ADDR0 = 32'h100; SIZE0 = 2; SIGN0 = 1;
    MEM_DOUT2 = 32'hDEADBEEF;
    rsp_q.push_back('{1'b0, 32'hDEADBEEF});
    tick();
    chk("rd0_access", {24'd0, outs()}, {24'd0, G0 | RD});
    chk("rd0_addr", MEM_ADDR2, 32'h100);
    chk("rd0_size_sign", {29'd0, MEM_SIZE, MEM_SIGN}, {29'd0, 2'd2, 1'b1});
    REQ0 = 0;
    tick();
    chk("rd0_resp", {24'd0, outs()}, {24'd0, RV0});
    pop_rsp("rd0");
    tick();
    chk("rd0_idle", {24'd0, outs()}, 32'd0);
    chk("rd0_rdata_idle", RDATA0, 32'd0);

    // DMA word write
    REQ1 = 1; WE1 = 1; ADDR1 = 32'h204; WDATA1 = 32'h12345678; SIZE1 = 2;
    tick();
    chk("wr1_access", {24'd0, outs()}, {24'd0, G1 | WR});
    chk("wr1_din", MEM_DIN2, 32'h12345678);
    chk("wr1_addr", MEM_ADDR2, 32'h204);
    REQ1 = 0; WE1 = 0;
    tick();
    chk("wr1_idle", {24'd0, outs()}, 32'd0);

    // Both requesters held for 4 reads: expect alternating grants starting with CPU
    REQ0 = 1; REQ1 = 1; ADDR0 = 32'h300; ADDR1 = 32'h400; SIZE0 = 2; SIZE1 = 2;
    ng = 0; nrv = 0;
    for (int c = 0; c < 30 && nrv < 4; c++) begin
      tick();
      if (GNT0 || GNT1) begin
        chk($sformatf("rr_owner%0d", ng), {31'd0, GNT1}, ng % 2);
        chk($sformatf("rr_strobes%0d", ng), {24'd0, outs()}, {24'd0, (GNT1 ? G1 : G0) | RD});
        chk($sformatf("rr_addr%0d", ng), MEM_ADDR2, (ng % 2) ? 32'h400 : 32'h300);
        MEM_DOUT2 = 32'hA5000000 + ng;
        rsp_q.push_back('{GNT1, MEM_DOUT2});
        ng++;
        if (ng == 4) begin
          REQ0 = 0; REQ1 = 0;
        end
      end
      if (RVALID0 || RVALID1) begin
        pop_rsp($sformatf("rr_rsp%0d", nrv));
        nrv++;
      end
    end
    chk("rr_responses", nrv, 4);
    tick();
    chk("rr_idle", {24'd0, outs()}, 32'd0);

    // Misaligned / illegal CPU reads are rejected in the grant cycle
    bad_addr[0] = 32'h102; bad_size[0] = 2'd2;
    bad_addr[1] = 32'h101; bad_size[1] = 2'd1;
    bad_addr[2] = 32'h100; bad_size[2] = 2'd3;
    for (int i = 0; i < 3; i++) begin
      REQ0 = 1; WE0 = 0; ADDR0 = bad_addr[i]; SIZE0 = bad_size[i];
      tick();
      chk($sformatf("err%0d_access", i), {24'd0, outs()}, {24'd0, G0 | E0});
      REQ0 = 0;
      tick();
      chk($sformatf("err%0d_no_rvalid", i), {24'd0, outs()}, 32'd0);
    end

    // Reset during ST_ACCESS of a read aborts it
    REQ0 = 1; WE0 = 0; ADDR0 = 32'h500; SIZE0 = 2;
    tick();
    chk("rst_access", {24'd0, outs()}, {24'd0, G0 | RD});
    RESET_N = 0; REQ0 = 0;
    #1;
    chk("rst_outs_zero", {24'd0, outs()}, 32'd0);
    chk("rst_addr_zero", MEM_ADDR2, 32'd0);
    tick();
    RESET_N = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rst_quiet%0d", i), {24'd0, outs()}, 32'd0);
    end
    REQ0 = 1; REQ1 = 1; ADDR0 = 32'h600; ADDR1 = 32'h700; SIZE0 = 2; SIZE1 = 2;
    MEM_DOUT2 = 32'h00000055;
    tick();
    chk("rst_cpu_first", {24'd0, outs()}, {24'd0, G0 | RD});
    rsp_q.push_back('{1'b0, 32'h00000055});
    REQ0 = 0; REQ1 = 0;
    tick();
    pop_rsp("rst_rsp");
    tick();
    chk("rst_idle", {24'd0, outs()}, 32'd0);

    // DMA request arriving during a CPU ST_ACCESS waits for ST_IDLE
    REQ0 = 1; WE0 = 0; ADDR0 = 32'h800; SIZE0 = 2;
    tick();
    chk("late_gnt0", {24'd0, outs()}, {24'd0, G0 | RD});
    g0_cyc = cyc;
    REQ0 = 0;
    REQ1 = 1; WE1 = 0; ADDR1 = 32'h900; SIZE1 = 2;
    MEM_DOUT2 = 32'h11111111;
    rsp_q.push_back('{1'b0, 32'h11111111});
    tick();
    chk("late_resp0", {24'd0, outs()}, {24'd0, RV0});
    pop_rsp("late_rsp0");
    tick();
    chk("late_idle", {24'd0, outs()}, 32'd0);
    tick();
    chk("late_gnt1", {24'd0, outs()}, {24'd0, G1 | RD});
    chk("late_gap", cyc - g0_cyc, 3);
    chk("late_addr1", MEM_ADDR2, 32'h900);
    MEM_DOUT2 = 32'h22222222;
    rsp_q.push_back('{1'b1, 32'h22222222});
    REQ1 = 0;
    tick();
    chk("late_resp1", {24'd0, outs()}, {24'd0, RV1});
    pop_rsp("late_rsp1");
    tick();
    chk("final_idle", {24'd0, outs()}, 32'd0);
    chk("scoreboard_empty", rsp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
